// File: rtl/rv_scan_decoder.sv
// rv_scan_decoder
// ---------------------------------------------------------------------------
// Inverse of the parallel-prefix scan unit. Given a prefix vector p (XOR, AND
// or OR scan of some d) it recovers the canonical d that re-scans exactly to
// p, and flags prefix vectors that no input could have produced.
//
// Two-stage valid/ready pipeline:
//   stage 1 holds the captured prefix vector,
//   stage 2 holds the decoded vector and its error flag.
// Latency is two cycles from input handshake to out_valid; throughput is one
// vector per cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   input vector present
//   in_ready   block can accept input (combinational from out_ready only)
//   in_data    prefix vector p
//   out_valid  result present
//   out_ready  consumer accepts result
//   out_data   recovered canonical d
//   out_err    p is not a legal prefix for OP (qualified by out_valid)
//   err_sticky set when an errored result is accepted, held until err_clear
//   err_count  saturating count of accepted errored results
//   err_clear  synchronous clear of err_sticky and err_count (wins over a
//              coincident errored transfer)
// ---------------------------------------------------------------------------
module rv_scan_decoder #(
  parameter int N       = 8,
  parameter int OP      = 2,
  parameter int REVERSE = 0,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clear
);

  // Identity element of the operator: fills the "previous" slot of the
  // boundary bit, which has no real predecessor.
  localparam logic IDENT = (OP == 32'sd1) ? 1'b1 : 1'b0;

  // Vector whose bit i is p[q(i)], with the boundary bit taking IDENT.
  function automatic logic [N-1:0] prev_of(input logic [N-1:0] p);
    logic [N-1:0] q;
    if (REVERSE == 32'sd0) begin
      q = {p[N-2:0], IDENT};
    end else begin
      q = {IDENT, p[N-1:1]};
    end
    return q;
  endfunction

  // Canonical inverse-scan: XOR differences, OR one-hot at the first 1,
  // AND one-cold at the first 0.
  function automatic logic [N-1:0] decode(input logic [N-1:0] p);
    logic [N-1:0] q;
    logic [N-1:0] d;
    q = prev_of(p);
    case (OP)
      32'sd0:  d = p ^ q;
      32'sd1:  d = p | ~q;
      32'sd2:  d = p & ~q;
      default: d = p ^ q;
    endcase
    return d;
  endfunction

  // OR prefixes can never fall from 1 back to 0 along the scan direction,
  // AND prefixes can never rise from 0 back to 1; XOR accepts anything.
  function automatic logic illegal(input logic [N-1:0] p);
    logic [N-1:0] q;
    logic         bad;
    q = prev_of(p);
    case (OP)
      32'sd1:  bad = |(~q & p);
      32'sd2:  bad = |(q & ~p);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  logic             s1_valid_r;
  logic [N-1:0]     s1_data_r;
  logic             s2_valid_r;
  logic [N-1:0]     s2_data_r;
  logic             s2_err_r;
  logic             err_sticky_r;
  logic [CNT_W-1:0] err_count_r;

  logic             out_fire_s;
  logic             s2_load_s;
  logic             s1_adv_s;
  logic             in_fire_s;
  logic [N-1:0]     dec_data_s;
  logic             dec_err_s;

  // Handshake network: stage 2 can take a new vector when empty or draining;
  // nothing here depends on in_valid, so in_ready never loops back to it.
  always_comb begin
    out_fire_s = s2_valid_r & out_ready;
    s2_load_s  = ~s2_valid_r | out_fire_s;
    s1_adv_s   = s1_valid_r & s2_load_s;
    in_ready   = ~s1_valid_r | s2_load_s;
    in_fire_s  = in_valid & in_ready;
    dec_data_s = decode(s1_data_r);
    dec_err_s  = illegal(s1_data_r);
  end

  // Stage 1: capture the raw prefix vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {N{1'b0}};
    end else if (in_fire_s) begin
      s1_valid_r <= 1'b1;
      s1_data_r  <= in_data;
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2: decoded vector and legality flag; held while the consumer stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_r <= 1'b0;
      s2_data_r  <= {N{1'b0}};
      s2_err_r   <= 1'b0;
    end else if (s1_adv_s) begin
      s2_valid_r <= 1'b1;
      s2_data_r  <= dec_data_s;
      s2_err_r   <= dec_err_s;
    end else if (out_fire_s) begin
      s2_valid_r <= 1'b0;
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

  // Error accounting on accepted results; a clear in the same cycle wins and
  // the coincident event is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_sticky_r <= 1'b0;
      err_count_r  <= {CNT_W{1'b0}};
    end else if (err_clear) begin
      err_sticky_r <= 1'b0;
      err_count_r  <= {CNT_W{1'b0}};
    end else if (out_fire_s && s2_err_r) begin
      err_sticky_r <= 1'b1;
      if (err_count_r != {CNT_W{1'b1}}) begin
        err_count_r <= err_count_r + CNT_W'(1'b1);
      end else begin
        err_count_r <= err_count_r;
      end
    end else begin
      err_sticky_r <= err_sticky_r;
      err_count_r  <= err_count_r;
    end
  end

  assign out_valid  = s2_valid_r;
  assign out_data   = s2_data_r;
  assign out_err    = s2_err_r;
  assign err_sticky = err_sticky_r;
  assign err_count  = err_count_r;

endmodule
